// File: rtl/tm1638_pkg.sv
// Shared word layout, TM1638 command bytes and sequencer states.
// Imported by the interface, the segment RAM and the frame sequencer.
package tm1638_pkg;

    localparam int WORD_W = 18;
    localparam int W_END  = 17;
    localparam int W_READ = 16;

    localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
    localparam logic [7:0] CMD_ADDR0      = 8'hC0;
    localparam logic [7:0] CMD_DCTRL      = 8'h80;
    localparam logic [7:0] CMD_READ_KEYS  = 8'h42;

    localparam int FRAME_WORDS = 24;
    localparam int KEY_BYTES   = 4;
    localparam int SEG_BYTES   = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        S_WAIT,
        S_MODE,
        S_ADDR,
        S_DATA,
        S_DCTRL,
        S_KCMD,
        S_KREAD,
        S_KCOLLECT
    } state_t;

    function automatic word_t mk_word(
        input logic       last,
        input logic       rd,
        input logic [7:0] b
    );
        word_t w;
        w         = '0;
        w[W_END]  = last;
        w[W_READ] = rd;
        w[7:0]    = b;
        return w;
    endfunction

endpackage

// File: rtl/tm1638_if.sv
// Push/read link between the frame sequencer and spi_fifo.
// master: sequencer (drives data_valid/data); slave: spi_fifo side.
interface tm1638_if;
    import tm1638_pkg::*;

    logic       fifo_full;
    logic       data_valid;
    word_t      data;
    logic       rd_valid;
    logic [7:0] rd_data;

    modport master (
        input  fifo_full, rd_valid, rd_data,
        output data_valid, data
    );

    modport slave (
        output fifo_full, rd_valid, rd_data,
        input  data_valid, data
    );

endinterface

// File: rtl/tm1638_seg_ram.sv
// 16x8 segment RAM: sync clear on rst, one write port, async read port.
// Ports: clk, rst, we/waddr/wdata (write), raddr/rdata (read-before-write).
module tm1638_seg_ram
    import tm1638_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [SEG_BYTES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SEG_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Async read: a same-edge write lands after the reader captured it.
    assign rdata = mem[raddr];

endmodule

// File: rtl/tm1638_ctrl.sv
// TM1638 frame sequencer: refresh frame + key scan pushed to spi_fifo.
// Ports: i_Clk/i_Rst, control (i_Enable, i_Force, seg RAM write, i_Bright,
// i_Disp_On), fifo link (tm1638_if.master), key outputs, o_Busy.
module tm1638_ctrl
    import tm1638_pkg::*;
#(
    parameter int REFRESH_CYCLES      = 100000,
    parameter int READ_TIMEOUT_CYCLES = 4096
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Enable,
    input  logic        i_Force,
    input  logic        i_Seg_We,
    input  logic [3:0]  i_Seg_Addr,
    input  logic [7:0]  i_Seg_Data,
    input  logic [2:0]  i_Bright,
    input  logic        i_Disp_On,
    tm1638_if.master    fifo,
    output logic [31:0] o_Keys,
    output logic        o_Keys_Valid,
    output logic        o_Key_Err,
    output logic        o_Busy
);

    // Words outside DATA/KREAD: MODE, ADDR, DCTRL, KCMD.
    localparam int KEY_WORDS = FRAME_WORDS - 4 - SEG_BYTES;
    localparam int CNT_MAX   = (REFRESH_CYCLES > READ_TIMEOUT_CYCLES) ?
                               REFRESH_CYCLES : READ_TIMEOUT_CYCLES;
    localparam int CW        = $clog2(CNT_MAX + 1);

    state_t         state, state_n;
    logic [3:0]     idx, idx_n;
    word_t          word, word_n;
    logic           pend, pend_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [1:0]     nbyte, nbyte_n;
    logic [23:0]    kbuf, kbuf_n;
    logic [31:0]    keys, keys_n;
    logic           kv_n, kerr_n;
    logic [3:0]     raddr;
    logic [7:0]     ram_q;
    logic           push;
    logic           expired;

    tm1638_seg_ram u_ram (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .we    (i_Seg_We),
        .waddr (i_Seg_Addr),
        .wdata (i_Seg_Data),
        .raddr (raddr),
        .rdata (ram_q)
    );

    // Next DATA word is read while the current one is being pushed.
    assign raddr   = (state == S_DATA) ? idx + 4'd1 : 4'd0;
    assign push    = fifo.data_valid;
    assign expired = (cnt == CW'(REFRESH_CYCLES - 1));

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state        <= S_WAIT;
            idx          <= '0;
            word         <= '0;
            pend         <= 1'b0;
            cnt          <= CW'(REFRESH_CYCLES - 1);
            nbyte        <= '0;
            kbuf         <= '0;
            keys         <= '0;
            o_Keys_Valid <= 1'b0;
            o_Key_Err    <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            word         <= word_n;
            pend         <= pend_n;
            cnt          <= cnt_n;
            nbyte        <= nbyte_n;
            kbuf         <= kbuf_n;
            keys         <= keys_n;
            o_Keys_Valid <= kv_n;
            o_Key_Err    <= kerr_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word;
        pend_n  = pend;
        cnt_n   = cnt;
        nbyte_n = nbyte;
        kbuf_n  = kbuf;
        keys_n  = keys;
        kv_n    = 1'b0;
        kerr_n  = 1'b0;
        unique case (state)
            S_WAIT: begin
                if (i_Force || (expired && i_Enable)) begin
                    state_n = S_MODE;
                    word_n  = mk_word(1'b1, 1'b0, CMD_WRITE_AUTO);
                    pend_n  = 1'b1;
                end else if (!expired) begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_MODE: if (push) begin
                state_n = S_ADDR;
                word_n  = mk_word(1'b0, 1'b0, CMD_ADDR0);
            end
            S_ADDR: if (push) begin
                state_n = S_DATA;
                idx_n   = '0;
                word_n  = mk_word(1'b0, 1'b0, ram_q);
            end
            S_DATA: if (push) begin
                if (idx == 4'd15) begin
                    state_n = S_DCTRL;
                    word_n  = mk_word(1'b1, 1'b0,
                        CMD_DCTRL | {4'b0, i_Disp_On, i_Bright});
                end else begin
                    idx_n  = idx + 4'd1;
                    word_n = mk_word(idx == 4'd14, 1'b0, ram_q);
                end
            end
            S_DCTRL: if (push) begin
                state_n = S_KCMD;
                word_n  = mk_word(1'b0, 1'b0, CMD_READ_KEYS);
            end
            S_KCMD: if (push) begin
                state_n = S_KREAD;
                idx_n   = '0;
                word_n  = mk_word(1'b0, 1'b1, 8'h00);
            end
            S_KREAD: if (push) begin
                if (idx == 4'(KEY_WORDS - 1)) begin
                    state_n = S_KCOLLECT;
                    pend_n  = 1'b0;
                    cnt_n   = CW'(1);
                    nbyte_n = '0;
                end else begin
                    idx_n  = idx + 4'd1;
                    word_n = mk_word(idx == 4'(KEY_WORDS - 2),
                                     1'b1, 8'h00);
                end
            end
            S_KCOLLECT: begin
                cnt_n = cnt + CW'(1);
                if (fifo.rd_valid) begin
                    if (nbyte == 2'(KEY_BYTES - 1)) begin
                        keys_n  = {fifo.rd_data, kbuf};
                        kv_n    = 1'b1;
                        state_n = S_WAIT;
                        cnt_n   = '0;
                    end else begin
                        // Bytes shift in from the top: {b2,b1,b0}.
                        kbuf_n  = {fifo.rd_data, kbuf[23:8]};
                        nbyte_n = nbyte + 2'd1;
                    end
                end else if (cnt == CW'(READ_TIMEOUT_CYCLES - 1)) begin
                    kerr_n  = 1'b1;
                    state_n = S_WAIT;
                    cnt_n   = '0;
                end
            end
            default: state_n = S_WAIT;
        endcase
    end

    assign fifo.data       = word;
    assign fifo.data_valid = pend & ~fifo.fifo_full;
    assign o_Keys          = keys;
    assign o_Busy          = (state != S_WAIT);

endmodule

// File: doc/tm1638_ctrl.md
Name: tm1638_ctrl

Overview:
Frame sequencer for the TM1638 display/keypad link. It holds a 16-byte segment RAM and periodically pushes a full refresh frame into spi_fifo as 18-bit command words. Each frame ends with a key scan: it issues read words, collects the 4 returned bytes and publishes a 32-bit key vector. It sits between the user logic (segment writes, brightness, key consumer) and spi_fifo.

Parameters:
REFRESH_CYCLES, 100000, clock cycles from the end of one frame to the start of the next (>=1)
READ_TIMEOUT_CYCLES, 4096, maximum cycles to wait for the 4 key bytes after the last read word is pushed

Ports:
i_Clk  in  1  clock
i_Rst  in  1  synchronous, active-high reset
i_Enable  in  1  frames are started only while high
i_Force  in  1  pulse: start a frame now if idle, without waiting for the timer
i_Seg_We  in  1  segment RAM write strobe
i_Seg_Addr  in  4  segment RAM address (TM1638 grid address 0..15)
i_Seg_Data  in  8  segment RAM write data
i_Bright  in  3  brightness, 0..7
i_Disp_On  in  1  display on/off
i_FIFO_Full  in  1  from spi_fifo o_FIFO_Full
o_Data_Valid  out  1  to spi_fifo i_Data_Valid
o_Data  out  18  to spi_fifo i_Data
i_Rd_Valid  in  1  from spi_fifo o_Data_Valid
i_Rd_Data  in  8  from spi_fifo o_Data
o_Keys  out  32  last key vector {byte3,byte2,byte1,byte0}
o_Keys_Valid  out  1  one-cycle pulse when o_Keys updates
o_Key_Err  out  1  one-cycle pulse on key-read timeout
o_Busy  out  1  high from frame start until return to WAIT

Behaviour:
- Word format: [17] END (release STB after this byte), [16] READ (byte clocked in from DIO), [15:8] zero, [7:0] byte. READ words carry byte 0x00.
- Push handshake: o_Data_Valid = word_pending & ~i_FIFO_Full. A word is consumed in every cycle o_Data_Valid=1, so at most 1 word/cycle. o_Data holds its value while pending.
- Reset: all outputs 0. o_Keys=0. Segment RAM is cleared to 0x00. The timer is preloaded as expired, so the first frame starts on the first cycle after reset release with i_Enable=1.
- States: WAIT -> MODE -> ADDR -> DATA(x16) -> DCTRL -> KCMD -> KREAD(x4) -> KCOLLECT -> WAIT.
  - MODE: 0x40 with END.
  - ADDR: 0xC0, no END.
  - DATA: RAM[0..15]; END only on index 15.
  - DCTRL: 0x80 | {i_Disp_On,i_Bright}, with END. i_Bright and i_Disp_On are sampled when this word is pushed.
  - KCMD: 0x42, no END.
  - KREAD: READ on all 4 words; END on the 4th.
  - KCOLLECT: waits for 4 i_Rd_Valid beats, assigned to byte0..byte3 in arrival order.
- One frame is 24 pushed words.
- WAIT: the counter runs 0..REFRESH_CYCLES-1 and the frame starts at expiry if i_Enable=1. If i_Enable=0 at expiry, the controller stays in WAIT with the counter saturated and starts as soon as i_Enable rises. i_Force in WAIT starts a frame next cycle. i_Force outside WAIT is ignored (not queued).
- Timeout: the counter starts when the 4th READ word is pushed. After READ_TIMEOUT_CYCLES without the 4th byte:
  - o_Key_Err pulses, o_Keys is unchanged, and the state returns to WAIT with the counter reset.
  - Bytes already collected are discarded.
- i_Rd_Valid outside KCOLLECT is ignored.
- On the 4th byte, o_Keys updates and o_Keys_Valid pulses in the same cycle. The state then returns to WAIT and the counter resets to 0.
- RAM writes are accepted every cycle, including mid-frame. DATA reads RAM live when each word is loaded, so a write to an address not yet sent appears in this frame; otherwise it appears next frame. On a same-cycle write and read of the same address, the old data is sent.
- i_Enable falling mid-frame does not abort the frame.
- Reset mid-frame returns to the reset state immediately; any words already in spi_fifo are not recalled.
- o_Busy=0 only in WAIT.

Decomposition:
- tm1638_pkg holds the word-field bit positions, the command constants (CMD_WRITE_AUTO=0x40, CMD_ADDR0=0xC0, CMD_DCTRL=0x80, CMD_READ_KEYS=0x42), the frame word count (24), the key byte count (4) and the state enum.
- One sub-module: tm1638_seg_ram, a 16x8 RAM with sync reset-clear, one write port and one read port with read-before-write.

Test Plan:
- Reset release with i_Enable=1 and FIFO never full -> words in order: 0x20040, 0x000C0, 0x00000 x15, 0x20000, 0x2008B (after setting i_Bright=3, i_Disp_On=1), 0x00042, 0x10000 x3, 0x30000. This is 24 consecutive o_Data_Valid cycles, then o_Busy high awaiting reads.
- Return i_Rd_Data 0x01, 0x00, 0x10, 0x80 -> o_Keys=0x80100001 with a one-cycle o_Keys_Valid pulse. The next frame starts REFRESH_CYCLES later (use REFRESH_CYCLES=50).
- Hold i_FIFO_Full=1 for 10 cycles mid-DATA -> o_Data_Valid stays 0 and o_Data is stable. The stream resumes without loss or duplication; word count is still 24.
- Write RAM[5]=0x3F before the frame and RAM[2]=0x06 while DATA index 8 is being sent -> this frame carries byte 5 = 0x3F and byte 2 = 0x00; the next frame carries byte 2 = 0x06.
- Supply only 3 read bytes with READ_TIMEOUT_CYCLES=20 -> o_Key_Err pulses 20 cycles after the 4th READ push and o_Keys is unchanged. A subsequent frame with 4 bytes succeeds.
- Assert i_Rst at DATA index 10 -> next cycle all outputs are 0. After release, a complete fresh 24-word frame starts with 0x20040 and RAM reads back all 0x00.
